// File: rtl/mod_ctrl_pkg.sv
// mod_ctrl_pkg: shared types and default divider codes for the ASK/FSK symbol sequencer.
package mod_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA} state_e;

    typedef enum logic {MODE_ASK, MODE_FSK} mode_e;

    typedef logic [3:0] div_code_t;

    localparam div_code_t MARK_CODE_DEF  = 4'b0011;
    localparam div_code_t SPACE_CODE_DEF = 4'b0110;

endpackage

// File: rtl/symbol_timer.sv
// symbol_timer: symbol-length down-counter; loads len_i on start_i, flags the final cycle of a symbol.
module symbol_timer #(
    parameter int SYM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [SYM_W-1:0] len_i,
    output logic             last_o,
    output logic             last_nxt_o
);

    logic [SYM_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = start_i ? len_i : (cnt_q != '0 ? cnt_q - SYM_W'(1) : cnt_q);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign last_o     = cnt_q == '0;
    assign last_nxt_o = cnt_d == '0;

endmodule

// File: rtl/mod_symbol_ctrl.sv
// mod_symbol_ctrl: serialises bytes MSB-first into divider codes and carrier gating for the ASK/FSK transmitter.
// Defining MOD_PREAMBLE_EN prefixes every frame started from IDLE with PRE_BYTE.
module mod_symbol_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int         SYM_W      = 16,
    parameter div_code_t  MARK_CODE  = MARK_CODE_DEF,
    parameter div_code_t  SPACE_CODE = SPACE_CODE_DEF,
    parameter logic [7:0] PRE_BYTE   = 8'hAA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [SYM_W-1:0] sym_len,
    output logic             div_msb,
    output logic [2:0]       div_cnt,
    output logic             div_load,
    output logic             tx_en,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       data_q, data_d;
    logic [SYM_W-1:0] len_q, len_d;
    logic [2:0]       bit_q, bit_d;
    div_code_t        code_q, code_d;
    logic             load_q, load_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic             last, last_nxt, xfer, sym_end, start, b_d;

    assign in_ready = !rst && (state_q == ST_IDLE || (state_q == ST_DATA && bit_q == 3'd0 && last));
    assign xfer     = in_valid && in_ready;
    assign sym_end  = state_q != ST_IDLE && last;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef MOD_PREAMBLE_EN
            ST_IDLE: if (xfer) state_d = ST_PRE;
`else
            ST_IDLE: if (xfer) state_d = ST_DATA;
`endif
            ST_PRE:  if (sym_end && bit_q == 3'd0) state_d = ST_DATA;
            ST_DATA: if (sym_end && bit_q == 3'd0) state_d = xfer ? ST_DATA : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Length is stored as L-1 so a zero request behaves like a one-cycle symbol.
    always_comb begin
        data_d = xfer ? in_data : data_q;
        mode_d = xfer ? mode_e'(mode) : mode_q;
        len_d  = xfer ? (sym_len == '0 ? '0 : sym_len - SYM_W'(1)) : len_q;
        bit_d  = xfer ? 3'd7 : (sym_end ? bit_q - 3'd1 : bit_q);
        start  = state_d != ST_IDLE && (xfer || sym_end);
    end

    symbol_timer #(.SYM_W(SYM_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .len_i      (len_d),
        .last_o     (last),
        .last_nxt_o (last_nxt)
    );

    // Outputs are registered, so they are decoded from the next-cycle view.
    always_comb begin
        b_d    = state_d == ST_PRE ? PRE_BYTE[bit_d] : data_d[bit_d];
        code_d = (state_d != ST_IDLE && mode_d == MODE_FSK && !b_d) ? SPACE_CODE : MARK_CODE;
        tx_d   = state_d != ST_IDLE && (mode_d == MODE_FSK || b_d);
        load_d = start;
        busy_d = state_d != ST_IDLE;
        done_d = state_d == ST_DATA && bit_d == 3'd0 && last_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            mode_q <= MODE_ASK;
            len_q  <= '0;
            bit_q  <= 3'd7;
            code_q <= MARK_CODE;
            load_q <= 1'b0;
            tx_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            mode_q <= mode_d;
            len_q  <= len_d;
            bit_q  <= bit_d;
            code_q <= code_d;
            load_q <= load_d;
            tx_q   <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign div_msb  = code_q[3];
    assign div_cnt  = code_q[2:0];
    assign div_load = load_q;
    assign tx_en    = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mod_symbol_ctrl.sv
// tb_mod_symbol_ctrl: scoreboard bench; each transfer pushes per-cycle expected outputs, popped cycle by cycle.
module tb_mod_symbol_ctrl;

    localparam logic [3:0] MARK  = 4'b0011;
    localparam logic [3:0] SPACE = 4'b0110;
    localparam logic [7:0] PRE   = 8'hAA;
`ifdef MOD_PREAMBLE_EN
    localparam bit PRE_ON = 1'b1;
`else
    localparam bit PRE_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] code;
        logic       load;
        logic       tx;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    localparam exp_t IDLE_EXP = '{code: MARK, load: 1'b0, tx: 1'b0, busy: 1'b0, done: 1'b0, rdy: 1'b1};
    localparam exp_t RST_EXP  = '{code: MARK, load: 1'b0, tx: 1'b0, busy: 1'b0, done: 1'b0, rdy: 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [15:0] sym_len = 16'd1;
    logic        div_msb, div_load, tx_en, busy, done;
    logic [2:0]  div_cnt;
    exp_t        obs, e;
    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mod_symbol_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sym_len  (sym_len),
        .div_msb  (div_msb),
        .div_cnt  (div_cnt),
        .div_load (div_load),
        .tx_en    (tx_en),
        .busy     (busy),
        .done     (done)
    );

    assign obs = {div_msb, div_cnt, div_load, tx_en, busy, done, in_ready};

    task automatic push_sym(input logic [7:0] bits, input logic m, input int l, input bit is_data);
        exp_t x;
        for (int s = 0; s < 8; s++)
            for (int c = 0; c < l; c++) begin
                x.code = (m && !bits[7-s]) ? SPACE : MARK;
                x.load = c == 0;
                x.tx   = m || bits[7-s];
                x.busy = 1'b1;
                x.done = is_data && s == 7 && c == l - 1;
                x.rdy  = x.done;
                q.push_back(x);
            end
    endtask

    task automatic push_frame(input logic [7:0] b, input logic m, input int l, input bit from_idle);
        if (PRE_ON && from_idle) push_sym(PRE, m, l, 1'b0);
        push_sym(b, m, l, 1'b1);
    endtask

    task automatic send(input logic [7:0] b, input logic m, input logic [15:0] len);
        in_data  = b;
        mode     = m;
        sym_len  = len;
        in_valid = 1'b1;
        push_frame(b, m, (len == 16'd0) ? 1 : int'(len), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hXX;
        sym_len  = 16'hFFFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== RST_EXP) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, RST_EXP); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (obs !== IDLE_EXP) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, IDLE_EXP); end
        @(negedge clk);
    endtask

    task automatic test_fsk_a5();
        int cyc = 0;
        send(8'hA5, 1'b1, 16'd4);
        while (q.size() != 0) begin
            e = q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL fsk_a5 cyc %0d: got %b want %b", cyc, obs, e); end
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (obs !== IDLE_EXP) begin n_fail++; $display("FAIL fsk_a5_idle: got %b want %b", obs, IDLE_EXP); end
    endtask

    task automatic test_ask_81();
        int cyc = 0;
        send(8'h81, 1'b0, 16'd2);
        while (q.size() != 0) begin
            e = q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL ask_81 cyc %0d: got %b want %b", cyc, obs, e); end
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (obs !== IDLE_EXP) begin n_fail++; $display("FAIL ask_81_idle: got %b want %b", obs, IDLE_EXP); end
    endtask

    task automatic test_len_zero();
        int cyc = 0;
        send(8'hFF, 1'b1, 16'd0);
        while (q.size() != 0) begin
            e = q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL len_zero cyc %0d: got %b want %b", cyc, obs, e); end
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (obs !== IDLE_EXP) begin n_fail++; $display("FAIL len_zero_idle: got %b want %b", obs, IDLE_EXP); end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int first = PRE_ON ? 48 : 24;
        int dones = 0;
        in_data  = 8'h0F;
        mode     = 1'b1;
        sym_len  = 16'd3;
        in_valid = 1'b1;
        push_frame(8'h0F, 1'b1, 3, 1'b1);
        push_frame(8'hF0, 1'b1, 3, 1'b0);
        @(negedge clk);
        in_data = 8'hF0;
        while (q.size() != 0) begin
            e = q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL b2b cyc %0d: got %b want %b", cyc, obs, e); end
            if (done === 1'b1) dones++;
            if (cyc == first) in_valid = 1'b0;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if (dones !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d want %0d", dones, 2); end
        n_tests++;
        if (obs !== IDLE_EXP) begin n_fail++; $display("FAIL b2b_idle: got %b want %b", obs, IDLE_EXP); end
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        send(8'hA5, 1'b1, 16'd4);
        repeat (10) begin
            e = q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL mid_reset_pre cyc %0d: got %b want %b", cyc, obs, e); end
            cyc++;
            @(negedge clk);
        end
        q.delete();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs !== RST_EXP) begin n_fail++; $display("FAIL mid_reset_hold: got %b want %b", obs, RST_EXP); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (obs !== IDLE_EXP) begin n_fail++; $display("FAIL mid_reset_idle: got %b want %b", obs, IDLE_EXP); end
        @(negedge clk);
        cyc = 0;
        send(8'h3C, 1'b0, 16'd1);
        while (q.size() != 0) begin
            e = q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL mid_reset_after cyc %0d: got %b want %b", cyc, obs, e); end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_preamble_00();
        int cyc = 0;
        int done_at = -1;
        send(8'h00, 1'b1, 16'd1);
        while (q.size() != 0) begin
            e = q.pop_front();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL pre_00 cyc %0d: got %b want %b", cyc, obs, e); end
            if (done === 1'b1) done_at = cyc + 1;
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (done_at !== (PRE_ON ? 16 : 8)) begin
            n_fail++;
            $display("FAIL pre_00_done_at: got k+%0d want k+%0d", done_at, PRE_ON ? 16 : 8);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int cyc = 0;
            logic [7:0] b = 8'($urandom);
            logic m = 1'($urandom);
            logic [15:0] l = 16'($urandom_range(0, 5));
            send(b, m, l);
            while (q.size() != 0) begin
                e = q.pop_front();
                n_tests++;
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL random b=%h m=%b l=%0d cyc %0d: got %b want %b", b, m, l, cyc, obs, e);
                end
                cyc++;
                @(negedge clk);
            end
            n_tests++;
            if (obs !== IDLE_EXP) begin n_fail++; $display("FAIL random_idle b=%h: got %b want %b", b, obs, IDLE_EXP); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fsk_a5();
        test_ask_81();
        test_len_zero();
        test_back_to_back();
        test_mid_reset();
        test_preamble_00();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
